// File: rtl/adder_result_collector_if.sv
// Operand/result handshake bundle between the adder environment and the result collector.
// The master drives the operand side; the slave is the collector.
interface adder_result_collector_if #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
    logic [CW-1:0]    count;
    logic             err;

    modport master (
        output en, in_valid, s, carry, out_ready,
        input  in_ready, out_valid, out_sum, count, err
    );

    modport slave (
        input  en, in_valid, s, carry, out_ready,
        output in_ready, out_valid, out_sum, count, err
    );
endinterface

// File: rtl/adder_result_collector.sv
// Tags operands entering a fully pipelined adder, captures each tagged {carry, s}
// into a FIFO, and uses credits so the FIFO can never overflow.
module adder_result_collector #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    adder_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_tag;
    logic [WIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_reserved;
    logic             r_err;

    logic w_in_ready;
    logic w_out_valid;
    logic w_issue;
    logic w_drop;
    logic w_capture;
    logic w_pop;

    always_comb begin
        w_in_ready  = (r_reserved < DEPTH_C);
        w_out_valid = (r_count != {CW{1'b0}});
        w_issue     = bus.in_valid & w_in_ready & bus.en;
        w_drop      = bus.in_valid & ~w_in_ready & bus.en;
        w_capture   = bus.en & r_tag[WIDTH-1];
        w_pop       = w_out_valid & bus.out_ready;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_mem[r_rd_ptr];
    assign bus.count     = r_count;
    assign bus.err       = r_err;

    // Tag bit i marks that the adder stage i+1 holds a real operand; moves in lock-step with the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag <= {WIDTH{1'b0}};
        end else if (bus.en) begin
            r_tag[0] <= w_issue;
            for (int i = 1; i < WIDTH; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {(WIDTH+1){1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
        end else if (w_capture) begin
            r_mem[r_wr_ptr] <= {bus.carry, bus.s};
            r_wr_ptr        <= r_wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= {AW{1'b0}};
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Occupancy: full/empty come from here, never from pointer comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Credits cover stored entries plus tagged in-flight operands, so captures leave them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reserved <= {CW{1'b0}};
        end else begin
            case ({w_issue, w_pop})
                2'b10:   r_reserved <= r_reserved + CNT_ONE;
                2'b01:   r_reserved <= r_reserved - CNT_ONE;
                default: r_reserved <= r_reserved;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_drop) begin
            r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adder_result_collector.sv
// Self-checking bench for adder_result_collector: directed scenarios plus a randomized
// run compared against a queue-based model of in-flight operands and stored results.
`timescale 1ns/1ps
module tb_adder_result_collector;
    localparam int W  = 3;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adder_result_collector_if #(.WIDTH(W), .DEPTH(D)) bus ();
    adder_result_collector #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   pipe [W];

    // Model: remaining enabled edges per in-flight operand, its sum, and stored results.
    int         m_t [$];
    logic [W:0] m_v [$];
    logic [W:0] m_f [$];
    bit         m_err;

    function automatic logic [W:0] sum3(input logic [W-1:0] x, input logic [W-1:0] y, input logic z);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, z};
    endfunction

    task automatic model_reset();
        m_t.delete();
        m_v.delete();
        m_f.delete();
        m_err = 1'b0;
    endtask

    // One clock: update the model from the inputs seen at this edge, then advance the adder stub.
    task automatic tick();
        bit         e, iv, orr, iss, pp;
        logic [W:0] sm;
        e   = bus.en;
        iv  = bus.in_valid;
        orr = bus.out_ready;
        sm  = sum3(a, b, c);
        iss = e && iv && ((m_t.size() + m_f.size()) < D);
        if (e && iv && !iss) m_err = 1'b1;
        pp = orr && (m_f.size() > 0);
        if (pp) void'(m_f.pop_front());
        if (e) begin
            for (int i = 0; i < m_t.size(); i++) m_t[i] = m_t[i] - 1;
            while (m_t.size() > 0 && m_t[0] == 0) begin
                void'(m_t.pop_front());
                m_f.push_back(m_v.pop_front());
            end
            if (iss) begin
                m_t.push_back(W);
                m_v.push_back(sm);
            end
        end
        @(posedge clk);
        #1;
        if (e) begin
            for (int i = W - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = sm;
        end
        {bus.carry, bus.s} = pipe[W-1];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        a = '0; b = '0; c = 1'b0;
        for (int i = 0; i < W; i++) pipe[i] = '0;
        {bus.carry, bus.s} = pipe[W-1];
        model_reset();
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_sum !== 4'd0) begin bad++; $display("FAIL reset_out_sum got=%h want=0", bus.out_sum); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bus.en = 1'b1; bus.out_ready = 1'b0;
        a = 3'd4; b = 3'd2; c = 1'b1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_early edge%0d out_valid=%b want=0", k, bus.out_valid); end
        end
        tick();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.out_sum !== 4'b0111) begin bad++; $display("FAIL single_sum got=%b want=0111", bus.out_sum); end
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", bus.count); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", bus.err); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL single_drain got=%0d want=0", bus.count); end
    endtask

    // stall=0: back-to-back issue; stall=1: en low on edges 2 and 3, everything shifts by two.
    task automatic run_trio(input bit stall);
        logic [W-1:0] ta [3];
        logic [W-1:0] tb_ [3];
        logic [W:0]   te [3];
        int first, last, idx;
        ta[0] = 3'd4; tb_[0] = 3'd2;
        ta[1] = 3'd4; tb_[1] = 3'd3;
        ta[2] = 3'd7; tb_[2] = 3'd7;
        te[0] = 4'd7; te[1] = 4'd8; te[2] = 4'b1111;
        first = stall ? 5 : 3;
        last  = first + 3;
        bus.out_ready = 1'b1;
        for (int k = 0; k <= last; k++) begin
            bus.en = !(stall && (k == 2 || k == 3));
            idx = (k < 2) ? k : 2;
            if (k <= (stall ? 4 : 2)) begin
                bus.in_valid = 1'b1; a = ta[idx]; b = tb_[idx]; c = 1'b1;
            end else begin
                bus.in_valid = 1'b0; a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            end
            tick();
            total++; if (bus.count > 3'd1) begin bad++; $display("FAIL trio%0d_count edge%0d got=%0d want<=1", stall, k, bus.count); end
            if (k >= first && k < last) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_sum !== te[k-first]) begin
                    bad++; $display("FAIL trio%0d_sum edge%0d got=%b/%b want=1/%b", stall, k, bus.out_valid, bus.out_sum, te[k-first]);
                end
            end else if (k == first - 1 || k == last) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL trio%0d_idle edge%0d out_valid=%b want=0", stall, k, bus.out_valid); end
            end
        end
        bus.en = 1'b1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_trio(1'b0);
    endtask

    task automatic test_stall();
        run_trio(1'b1);
    endtask

    task automatic test_backpressure();
        logic [W:0] exp_q [$];
        bus.en = 1'b1;
        for (int burst = 0; burst < 2; burst++) begin
            exp_q.delete();
            bus.out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                bus.in_valid = 1'b1;
                a = W'($urandom); b = W'($urandom); c = 1'($urandom);
                exp_q.push_back(sum3(a, b, c));
                tick();
                total++;
                if (bus.in_ready !== (k < 3)) begin bad++; $display("FAIL bp%0d_in_ready edge%0d got=%b want=%b", burst, k, bus.in_ready, (k < 3)); end
            end
            bus.in_valid = 1'b0;
            for (int k = 4; k < 7; k++) begin
                tick();
                total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_held edge%0d in_ready=%b want=0", burst, k, bus.in_ready); end
            end
            total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL bp%0d_full got=%0d want=4", burst, bus.count); end
            total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL bp%0d_err got=%b want=0", burst, bus.err); end
            bus.out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_q[k]) begin
                    bad++; $display("FAIL bp%0d_order entry%0d got=%b/%h want=1/%h", burst, k, bus.out_valid, bus.out_sum, exp_q[k]);
                end
                tick();
                if (k == 0) begin
                    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp%0d_credit in_ready=%b want=1", burst, bus.in_ready); end
                end
            end
            total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL bp%0d_empty got=%0d want=0", burst, bus.count); end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_violation();
        logic [W:0] exp_q [$];
        bus.en = 1'b1; bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            if (k < 4) exp_q.push_back(sum3(a, b, c));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL viol_err got=%b want=1", bus.err); end
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL viol_count got=%0d want=4", bus.count); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.out_sum !== exp_q[k]) begin bad++; $display("FAIL viol_order entry%0d got=%h want=%h", k, bus.out_sum, exp_q[k]); end
            tick();
        end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL viol_extra out_valid=%b want=0", bus.out_valid); end
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL viol_sticky err=%b want=1", bus.err); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_midflight();
        bus.en = 1'b1; bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; a = 3'd5; b = 3'd6; c = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL mid_pre count=%0d want=1", bus.count); end
        #3 rst = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", bus.count); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", bus.err); end
        model_reset();
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
                bad++; $display("FAIL mid_ghost edge%0d out_valid=%b count=%0d want=0/0", k, bus.out_valid, bus.count);
            end
        end
    endtask

    task automatic test_random();
        bit            allowed;
        logic [CW-1:0] exp_cnt;
        for (int k = 0; k < 600; k++) begin
            bus.en        = ($urandom_range(0, 4) != 0);
            allowed       = ((m_t.size() + m_f.size()) < D);
            bus.in_valid  = allowed ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 40) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            tick();
            exp_cnt = CW'(m_f.size());
            total++; if (bus.count !== exp_cnt) begin bad++; $display("FAIL rnd_count cyc%0d got=%0d want=%0d", k, bus.count, exp_cnt); end
            total++; if (bus.out_valid !== (m_f.size() > 0)) begin bad++; $display("FAIL rnd_valid cyc%0d got=%b want=%b", k, bus.out_valid, (m_f.size() > 0)); end
            total++;
            if (bus.in_ready !== ((m_t.size() + m_f.size()) < D)) begin
                bad++; $display("FAIL rnd_in_ready cyc%0d got=%b want=%b", k, bus.in_ready, ((m_t.size() + m_f.size()) < D));
            end
            total++; if (bus.err !== m_err) begin bad++; $display("FAIL rnd_err cyc%0d got=%b want=%b", k, bus.err, m_err); end
            if (m_f.size() > 0) begin
                total++; if (bus.out_sum !== m_f[0]) begin bad++; $display("FAIL rnd_sum cyc%0d got=%h want=%h", k, bus.out_sum, m_f[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_violation();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
